// File: rtl/tone_pkg.sv
// Shared types and default constants for the multi-channel tone generator.
// Optional sweep logic is compiled in with MULTI_TONE_SWEEP_EN.
package tone_pkg;

   localparam int unsigned CNT_W        = 16;
   localparam int unsigned PRESCALE_W   = 9;
   localparam int unsigned SWEEP_MIN    = 16;
   localparam int unsigned MAX_CHANNELS = 16;

   typedef logic [CNT_W-1:0]                 half_period_t;
   typedef logic [$clog2(MAX_CHANNELS)-1:0]  chan_idx_t;

   // Channel-index width, never narrower than one bit.
   function automatic int unsigned chan_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tone_channel.sv
// One square-wave tone channel: half-period counter, toggle and optional sawtooth sweep.
// Sweep behaviour is compiled in only with MULTI_TONE_SWEEP_EN.
module tone_channel #(
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned SWEEP_MIN = 16
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             wr_en_i,
   input  logic [CNT_W-1:0] wr_half_period_i,
   input  logic             wr_sweep_i,
   input  logic             sweep_tick_i,
   output logic             tone_o,
   output logic             active_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] base_q, base_d;
   logic [CNT_W-1:0] cur_h, cur_nxt;
   logic             tone_q, tone_d;
   logic             active_q;

`ifdef MULTI_TONE_SWEEP_EN
   logic [CNT_W-1:0] cur_q, cur_d;
   logic             sweep_q, sweep_d;

   assign cur_h   = cur_q;
   assign cur_nxt = cur_d;

   // Sawtooth: step down each tick, reload from base once at or below the floor.
   always_comb begin
      cur_d   = cur_q;
      sweep_d = sweep_q;
      if (sweep_tick_i && sweep_q && (cur_q != '0)) begin
         cur_d = (cur_q <= CNT_W'(SWEEP_MIN)) ? base_q : (cur_q - CNT_W'(1));
      end
      if (wr_en_i) begin
         cur_d   = wr_half_period_i;
         sweep_d = wr_sweep_i;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         cur_q   <= '0;
         sweep_q <= 1'b0;
      end else begin
         cur_q   <= cur_d;
         sweep_q <= sweep_d;
      end
   end
`else
   logic [CNT_W:0] unused_sweep;

   assign cur_h        = base_q;
   assign cur_nxt      = base_d;
   assign unused_sweep = {wr_sweep_i ^ sweep_tick_i, CNT_W'(SWEEP_MIN)};
`endif

   // The >= compare lets a shrinking half-period toggle at once instead of wrapping.
   always_comb begin
      cnt_d  = cnt_q;
      tone_d = tone_q;
      base_d = base_q;
      if (cur_h == '0) begin
         cnt_d  = '0;
         tone_d = 1'b0;
      end else if (cnt_q >= (cur_h - CNT_W'(1))) begin
         cnt_d  = '0;
         tone_d = ~tone_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      if (wr_en_i) begin
         base_d = wr_half_period_i;
         cnt_d  = '0;
         tone_d = 1'b0;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         cnt_q    <= '0;
         base_q   <= '0;
         tone_q   <= 1'b0;
         active_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         base_q   <= base_d;
         tone_q   <= tone_d;
         active_q <= (cur_nxt != '0);
      end
   end

   assign tone_o   = tone_q;
   assign active_o = active_q;

endmodule

// File: rtl/multi_tone_generator.sv
// Multi-channel square-wave tone generator: write decode, ready flag and sweep prescaler.
// Define MULTI_TONE_SWEEP_EN to compile in the prescaler and downward frequency sweep.
module multi_tone_generator
   import tone_pkg::chan_w;
#(
   parameter int unsigned CHANNELS   = 4,
   parameter int unsigned CNT_W      = tone_pkg::CNT_W,
   parameter int unsigned PRESCALE_W = tone_pkg::PRESCALE_W,
   parameter int unsigned SWEEP_MIN  = tone_pkg::SWEEP_MIN
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          cfg_valid,
   output logic                          cfg_ready,
   input  logic [chan_w(CHANNELS)-1:0]   cfg_chan,
   input  logic [CNT_W-1:0]              cfg_half_period,
   input  logic                          cfg_sweep,
   output logic [CHANNELS-1:0]           tone,
   output logic [CHANNELS-1:0]           active
);

   localparam int unsigned CHAN_W = chan_w(CHANNELS);

   logic ready_q;
   logic sweep_tick;

   always_ff @(posedge clock) begin
      if (reset) begin
         ready_q <= 1'b0;
      end else begin
         ready_q <= 1'b1;
      end
   end

   assign cfg_ready = ready_q;

`ifdef MULTI_TONE_SWEEP_EN
   logic [PRESCALE_W-1:0] presc_q, presc_d;

   assign presc_d    = presc_q + PRESCALE_W'(1);
   assign sweep_tick = &presc_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end
`else
   logic [PRESCALE_W-1:0] unused_presc;

   assign unused_presc = '0;
   assign sweep_tick   = 1'b0;
`endif

   // Out-of-range channel indices match no instance and are dropped.
   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      logic wr_en;

      assign wr_en = cfg_valid && ready_q && (cfg_chan == CHAN_W'(g));

      tone_channel #(
         .CNT_W     (CNT_W),
         .SWEEP_MIN (SWEEP_MIN)
      ) u_chan (
         .clock_i          (clock),
         .reset_i          (reset),
         .wr_en_i          (wr_en),
         .wr_half_period_i (cfg_half_period),
         .wr_sweep_i       (cfg_sweep),
         .sweep_tick_i     (sweep_tick),
         .tone_o           (tone[g]),
         .active_o         (active[g])
      );
   end

endmodule

// File: tb/tb_multi_tone_generator.sv
// Self-checking bench for multi_tone_generator: directed table, corner sequences, random vs model.
// Adapts its expectations to whether MULTI_TONE_SWEEP_EN is defined.
module tb_multi_tone_generator;

   localparam int CH   = 5;
   localparam int CW   = 16;
   localparam int PW   = 3;
   localparam int SMIN = 16;
`ifdef MULTI_TONE_SWEEP_EN
   localparam bit SWEEP_BUILD = 1'b1;
`else
   localparam bit SWEEP_BUILD = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [2:0]    cfg_chan;
   logic [CW-1:0] cfg_half_period;
   logic          cfg_sweep;
   logic [CH-1:0] tone;
   logic [CH-1:0] active;

   multi_tone_generator #(
      .CHANNELS   (CH),
      .CNT_W      (CW),
      .PRESCALE_W (PW),
      .SWEEP_MIN  (SMIN)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .cfg_valid       (cfg_valid),
      .cfg_ready       (cfg_ready),
      .cfg_chan        (cfg_chan),
      .cfg_half_period (cfg_half_period),
      .cfg_sweep       (cfg_sweep),
      .tone            (tone),
      .active          (active)
   );

   always #5 clock = ~clock;

   // Reference model: absolute edge timestamps rather than per-channel counters.
   int m_base [CH];
   int m_cur  [CH];
   int m_last [CH];
   bit m_tone [CH];
   bit m_sw   [CH];
   int now     = 0;
   int since   = 0;
   bit m_ready = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int chan;
      int hp;
      int rise;
      int period;
   } vec_t;

   vec_t tbl [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_update();
      bit tick;
      bit rdy_old;
      int per;
      per     = 1 << PW;
      rdy_old = m_ready;
      now++;
      if (reset) begin
         for (int c = 0; c < CH; c++) begin
            m_base[c] = 0;
            m_cur[c]  = 0;
            m_sw[c]   = 1'b0;
            m_tone[c] = 1'b0;
            m_last[c] = now;
         end
         since   = 0;
         m_ready = 1'b0;
      end else begin
         tick = SWEEP_BUILD && ((since % per) == (per - 1));
         since++;
         for (int c = 0; c < CH; c++) begin
            if (m_cur[c] == 0) begin
               m_tone[c] = 1'b0;
               m_last[c] = now;
            end else if ((now - m_last[c]) >= m_cur[c]) begin
               m_tone[c] = ~m_tone[c];
               m_last[c] = now;
            end
            if (tick && m_sw[c] && (m_cur[c] != 0))
               m_cur[c] = (m_cur[c] <= SMIN) ? m_base[c] : (m_cur[c] - 1);
            if (cfg_valid && rdy_old && (cfg_chan == 3'(c))) begin
               m_base[c] = int'(cfg_half_period);
               m_cur[c]  = int'(cfg_half_period);
               m_tone[c] = 1'b0;
               m_last[c] = now;
               m_sw[c]   = SWEEP_BUILD && cfg_sweep;
            end
         end
         m_ready = 1'b1;
      end
   endtask

   task automatic step();
      logic [CH-1:0] et;
      logic [CH-1:0] ea;
      @(posedge clock);
      model_update();
      #1;
      for (int c = 0; c < CH; c++) begin
         et[c] = m_tone[c];
         ea[c] = (m_cur[c] != 0);
      end
      chk("model_tone", 32'(tone), 32'(et));
      chk("model_active", 32'(active), 32'(ea));
      chk("model_ready", 32'(cfg_ready), 32'(m_ready));
   endtask

   task automatic wr(input int c, input int h, input bit sw);
      cfg_valid       = 1'b1;
      cfg_chan        = 3'(c);
      cfg_half_period = CW'(h);
      cfg_sweep       = sw;
      step();
      cfg_valid       = 1'b0;
      cfg_sweep       = 1'b0;
   endtask

   task automatic wait_rise(input int c, output int n);
      logic prev;
      int   k;
      prev = tone[c];
      n    = -1;
      k    = 0;
      while (n < 0 && k < 300) begin
         step();
         k++;
         if (!prev && tone[c]) n = k;
         prev = tone[c];
      end
   endtask

   task automatic wait_toggle(input int c, output int n);
      logic prev;
      int   k;
      prev = tone[c];
      n    = -1;
      k    = 0;
      while (n < 0 && k < 100) begin
         step();
         k++;
         if (tone[c] !== prev) n = k;
      end
   endtask

   initial begin
      int n;
      int n_short;

      tbl[0] = '{chan: 0, hp: 6, rise: 6, period: 12};
      tbl[1] = '{chan: 3, hp: 1, rise: 1, period: 2};
      tbl[2] = '{chan: 4, hp: 9, rise: 9, period: 18};
      tbl[3] = '{chan: 1, hp: 4, rise: 4, period: 8};

      reset           = 1'b1;
      cfg_valid       = 1'b0;
      cfg_chan        = '0;
      cfg_half_period = '0;
      cfg_sweep       = 1'b0;
      step();
      step();
      chk("reset_tone", 32'(tone), 32'(0));
      chk("reset_active", 32'(active), 32'(0));
      chk("reset_ready", 32'(cfg_ready), 32'(0));
      reset = 1'b0;
      step();
      chk("ready_after_reset", 32'(cfg_ready), 32'(1));

      // Directed table: first rising edge latency and full period per channel.
      for (int i = 0; i < 4; i++) begin
         wr(tbl[i].chan, tbl[i].hp, 1'b0);
         chk("tbl_active", 32'(active[tbl[i].chan]), 32'(1));
         wait_rise(tbl[i].chan, n);
         chk("tbl_first_rise", 32'(n), 32'(tbl[i].rise));
         wait_rise(tbl[i].chan, n);
         chk("tbl_period", 32'(n), 32'(tbl[i].period));
      end

      wr(6, 5, 1'b0);
      chk("out_of_range_ignored", 32'(active), 32'(5'b11011));

      wr(1, 0, 1'b0);
      chk("disable_tone", 32'(tone[1]), 32'(0));
      chk("disable_active", 32'(active[1]), 32'(0));

      // Rewrite lands exactly on the edge where the old setting would toggle.
      wr(2, 3, 1'b0);
      step();
      step();
      wr(2, 5, 1'b0);
      chk("collide_tone_low", 32'(tone[2]), 32'(0));
      wait_rise(2, n);
      chk("collide_first_rise", 32'(n), 32'(5));
      wait_rise(2, n);
      chk("collide_period", 32'(n), 32'(10));

      // Sweep from 18 down to the floor and back; every half-cycle stays in 16..18.
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      wr(0, 18, 1'b1);
      n_short = 0;
      for (int i = 0; i < 20; i++) begin
         wait_toggle(0, n);
         if (SWEEP_BUILD) begin
            chk("sweep_interval_in_range", 32'((n >= 16) && (n <= 18)), 32'(1));
            if (n != 18) n_short++;
         end else begin
            chk("fixed_interval", 32'(n), 32'(18));
         end
      end
      if (SWEEP_BUILD) chk("sweep_shortened", 32'(n_short > 0), 32'(1));

      reset = 1'b1;
      step();
      chk("midreset_tone", 32'(tone), 32'(0));
      chk("midreset_active", 32'(active), 32'(0));
      chk("midreset_ready", 32'(cfg_ready), 32'(0));
      reset = 1'b0;
      step();
      chk("midreset_ready_back", 32'(cfg_ready), 32'(1));

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         int r;
         reset     = ($urandom_range(0, 499) == 0);
         cfg_valid = ($urandom_range(0, 3) == 0);
         cfg_chan  = 3'($urandom_range(0, 7));
         cfg_sweep = 1'($urandom_range(0, 1));
         r = $urandom_range(0, 9);
         if (r == 0)      cfg_half_period = '0;
         else if (r == 1) cfg_half_period = CW'($urandom_range(1, 3));
         else             cfg_half_period = CW'($urandom_range(14, 24));
         step();
      end
      reset     = 1'b0;
      cfg_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/multi_tone_generator.md
MULTI_TONE_GENERATOR -- requirements
Module: multi_tone_generator

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, number of independent tone channels (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 16, width of half-period values and channel counters.
REQ-003 The block SHALL have parameter PRESCALE_W, default 9, width of the free-running sweep prescaler.
REQ-004 The block SHALL have parameter SWEEP_MIN, default 16, lowest half-period reached by a sweep.
REQ-005 The block SHALL have port clock  input  1  the single system clock; all logic on its rising edge.
REQ-006 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 The block SHALL have port cfg_valid  input  1  configuration write request.
REQ-008 The block SHALL have port cfg_ready  output  1  block accepts a write this cycle.
REQ-009 The block SHALL have port cfg_chan  input  $clog2(CHANNELS) (min 1)  target channel index.
REQ-010 The block SHALL have port cfg_half_period  input  CNT_W  clocks per output half-cycle; 0 disables the channel.
REQ-011 The block SHALL have port cfg_sweep  input  1  enable downward frequency sweep for the target channel.
REQ-012 The block SHALL have port tone  output  CHANNELS  per-channel square-wave outputs.
REQ-013 The block SHALL have port active  output  CHANNELS  per-channel flag, high while the channel's half-period is non-zero.

Function
REQ-014 A write SHALL transfer on a rising edge with cfg_valid=1 and cfg_ready=1; cfg_chan >= CHANNELS SHALL be ignored.
REQ-015 cfg_ready SHALL be 0 during reset and 1 on every cycle after the first cycle with reset=0.
REQ-016 On transfer, the target channel SHALL load base and current half-period with cfg_half_period, clear its counter, drive tone low, and latch cfg_sweep, all visible the next cycle.
REQ-017 For an enabled channel with current half-period H, the counter SHALL count 0..H-1 and tone SHALL toggle, with the counter cleared, on the cycle the counter is >= H-1; output period is 2H clocks.
REQ-018 A write accepted at edge t with H>=1 SHALL produce the first tone rising edge at edge t+H.
REQ-019 H=0 SHALL hold tone low, counter at 0 and active low; active SHALL equal (current half-period != 0).
REQ-020 A write to a channel on the same edge as its toggle SHALL take priority; the toggle is discarded.
REQ-021 Channels SHALL be fully independent; a write to one channel SHALL NOT disturb the counter or tone of any other.
REQ-022 A free-running PRESCALE_W-bit prescaler SHALL assert a one-cycle sweep tick when it equals all-ones, i.e. every 2^PRESCALE_W clocks.
REQ-023 On a sweep tick, each sweeping enabled channel SHALL decrement its current half-period by 1, or reload it from base if current <= SWEEP_MIN, producing a wrap-around sawtooth sweep.
REQ-024 A channel loaded with base <= SWEEP_MIN and sweep set SHALL hold base constant.
REQ-025 The >= comparison SHALL guarantee a toggle within one clock when a decrement leaves the counter above H-1; counters SHALL never wrap through 2^CNT_W.
REQ-026 A write and a sweep tick to the same channel on the same edge SHALL resolve in favour of the write.

Reset
REQ-027 Reset SHALL clear all counters, base and current half-periods, sweep flags and the prescaler to 0, and drive tone=0, active=0, cfg_ready=0.
REQ-028 Reset asserted mid-operation SHALL take effect on the next edge regardless of pending writes or ticks.

Configuration
REQ-029 Macro MULTI_TONE_SWEEP_EN defined SHALL compile in the prescaler and sweep logic of REQ-022 to REQ-026.
REQ-030 Without MULTI_TONE_SWEEP_EN, cfg_sweep SHALL be ignored, no prescaler SHALL exist, and current half-period SHALL always equal base.

Structure
REQ-031 Package tone_pkg SHALL hold the half-period typedef (CNT_W bits), channel-index typedef, and default constants CNT_W, PRESCALE_W, SWEEP_MIN.
REQ-032 Per-channel logic SHALL live in sub-module tone_channel, instantiated CHANNELS times, with the prescaler and write decode in the top level.

Verification
REQ-033 Write chan 0, H=6, no sweep -> tone[0] rises 6 clocks after accept, period 12 clocks, 50% duty; active[0]=1.
REQ-034 Write chan 1, H=0 after running at H=4 -> tone[1] low from next cycle, active[1]=0; chan 0 waveform unchanged.
REQ-035 Write chan 2, H=5 on the exact edge its counter would toggle -> toggle suppressed, tone[2] low, new period 10 starts.
REQ-036 PRESCALE_W=3, SWEEP_MIN=16, write chan 0, H=18, sweep=1 -> H steps 18,17,16,18 at 8-clock ticks; no missed toggles.
REQ-037 Assert reset for 1 cycle mid-sweep -> next cycle all tone=0, active=0, cfg_ready=0; cfg_ready=1 the cycle after reset=0.
REQ-038 Build without MULTI_TONE_SWEEP_EN, repeat REQ-036 stimulus -> H fixed at 18, period 36 clocks.
